jump_ctrl: RTL

JUMP_CTRL -- requirements
Module: jump_ctrl

---
 rtl/jump_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/jump_ctrl.sv
// Jump controller: launches the program counter, issues conditional relative jumps
// from a writable offset table, and latches program completion until reset.
module jump_ctrl #(
    parameter int D = 12,
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_req,
    input  logic         branch_op,
    input  logic         halt_op,
    input  logic         cond_flag,
    input  logic [L-1:0] lut_idx,
    input  logic         lut_wr_en,
    input  logic [L-1:0] lut_wr_idx,
    input  logic [D-1:0] lut_wr_data,
    input  logic [D-1:0] prog_ctr,
    output logic         start,
    output logic         done,
    output logic         reljump_en,
    output logic [D-1:0] offset,
    output logic [7:0]   jump_count,
    output logic [1:0]   state_dbg
);

    localparam int N = 1 << L;

    // Encoding is visible on state_dbg: 0 IDLE, 1 LAUNCH, 2 RUN, 3 HALTED.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         done_q, done_d;
    logic [7:0]   jump_count_q, jump_count_d;
    logic [D-1:0] table_q [N];
    logic [D-1:0] table_d [N];
    logic [D-1:0] entry;

    assign entry = table_q[lut_idx];

    always_comb begin
        state_d      = state_q;
        table_d      = table_q;
        start        = 1'b0;
        reljump_en   = 1'b0;
        offset       = '0;
        jump_count_d = jump_count_q;
        case (state_q)
            IDLE: begin
                if (lut_wr_en) table_d[lut_wr_idx] = lut_wr_data;
                if (start_req) state_d = LAUNCH;
            end
            LAUNCH: begin
                start   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                // A zero offset would be a no-op jump, so it is reported as not taken.
                reljump_en = branch_op & cond_flag & ~halt_op & (entry != '0);
                if (reljump_en) begin
                    offset = entry;
                    if (jump_count_q != 8'hFF) jump_count_d = jump_count_q + 8'd1;
                end
                if (halt_op || (prog_ctr == {D{1'b1}})) state_d = HALTED;
            end
            default: state_d = HALTED;
        endcase
        done_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            jump_count_q <= '0;
            for (int i = 0; i < N; i++) table_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            jump_count_q <= jump_count_d;
            table_q      <= table_d;
        end
    end

    assign done       = done_q;
    assign jump_count = jump_count_q;
    assign state_dbg  = state_q;

endmodule
